button_debouncer: RTL and testbench

//  Multi-channel debouncer for raw pushbutton/switch inputs. Synchronises each

---
 rtl/button_debouncer.sv | 101 ++++++++++
 tb/tb_button_debouncer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Multi-channel pushbutton debouncer: 2-flop synchroniser, shared sample-tick
// prescaler and a per-channel stability counter gating each output flip.
module button_debouncer #(
  parameter int WIDTH        = 4,
  parameter int TICK_DIV     = 1000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_out,
  output logic [WIDTH-1:0] btn_changed
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS + 1) : 1;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } chan_state_e;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [PW-1:0]    r_presc;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_chg;

  logic             w_tick;
  logic [PW-1:0]    w_presc_nxt;
  chan_state_e      w_state   [WIDTH];
  logic [CW-1:0]    w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0] w_out_nxt;
  logic [WIDTH-1:0] w_chg_nxt;

  assign w_tick      = (r_presc == PW'(TICK_DIV - 1));
  assign w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_presc <= '0;
      r_out   <= '0;
      r_chg   <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
      r_presc <= w_presc_nxt;
      r_out   <= w_out_nxt;
      r_chg   <= w_chg_nxt;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  // State is implied by the counter: zero means the output agrees with input.
  always_comb begin
    w_out_nxt = r_out;
    w_chg_nxt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_state[i]   = (r_cnt[i] == '0) ? ST_STABLE : ST_PENDING;
      w_cnt_nxt[i] = r_cnt[i];
      if (w_tick) begin
        unique case (w_state[i])
          ST_STABLE: begin
            if (r_sync2[i] != r_out[i]) begin
              if (STABLE_TICKS == 1) begin
                w_out_nxt[i] = r_sync2[i];
                w_chg_nxt[i] = 1'b1;
              end else begin
                w_cnt_nxt[i] = CW'(1);
              end
            end
          end
          ST_PENDING: begin
            if (r_sync2[i] == r_out[i]) begin
              w_cnt_nxt[i] = '0;
            end else if (r_cnt[i] == CW'(STABLE_TICKS - 1)) begin
              w_out_nxt[i] = r_sync2[i];
              w_chg_nxt[i] = 1'b1;
              w_cnt_nxt[i] = '0;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] + CW'(1);
            end
          end
          default: w_cnt_nxt[i] = '0;
        endcase
      end
    end
  end

  assign btn_out     = r_out;
  assign btn_changed = r_chg;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer (WIDTH=4, TICK_DIV=4, STABLE_TICKS=3).
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_in;
  logic [3:0] btn_out;
  logic [3:0] btn_changed;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  typedef struct {
    logic [3:0]  out;
    logic [3:0]  chg;
    int unsigned t0;
    int unsigned lo;
    int unsigned hi;
  } exp_t;

  exp_t exp_q [$];

  button_debouncer #(
    .WIDTH       (4),
    .TICK_DIV    (4),
    .STABLE_TICKS(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .btn_out    (btn_out),
    .btn_changed(btn_changed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Latency window 11..14 clk from the input edge (or reset release).
  task automatic push_exp(input logic [3:0] out, input logic [3:0] chg);
    exp_t e;
    e.out = out;
    e.chg = chg;
    e.t0  = cyc;
    e.lo  = 11;
    e.hi  = 14;
    exp_q.push_back(e);
  endtask

  task automatic drain(input logic [3:0] level);
    int unsigned budget = 40;
    while (exp_q.size() != 0 && budget != 0) begin
      @(posedge clk);
      budget--;
    end
    chk("drain", exp_q.size(), 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("settled_level", btn_out, level);
  endtask

  task automatic step(input logic [3:0] val, input logic [3:0] chg);
    @(posedge clk); #1;
    btn_in = val;
    push_exp(val, chg);
    drain(val);
  endtask

  always @(negedge clk) begin
    if (!reset && btn_changed != 4'h0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", btn_changed, 4'h0);
      end else begin
        exp_t e;
        int unsigned lat;
        e   = exp_q.pop_front();
        lat = cyc - e.t0;
        chk("out", btn_out, e.out);
        chk("chg", btn_changed, e.chg);
        chk("lat_min", lat >= e.lo, 1);
        chk("lat_max", lat <= e.hi, 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    btn_in = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out", btn_out, 4'h0);
    chk("reset_chg", btn_changed, 4'h0);

    @(posedge clk); #1;
    reset = 1'b0;
    push_exp(4'hF, 4'hF);
    drain(4'hF);

    step(4'h0, 4'hF);
    step(4'h1, 4'h1);

    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      btn_in = 4'h3;
      repeat (8) @(posedge clk);
      #1;
      btn_in = 4'h1;
      repeat (4) @(posedge clk);
      #1;
    end
    btn_in = 4'h3;
    push_exp(4'h3, 4'h2);
    drain(4'h3);

    step(4'h2, 4'h1);
    step(4'hB, 4'h9);
    step(4'h0, 4'hB);

    // Build up two pending ticks on bit 2, then reset must discard them.
    @(posedge clk); #1;
    btn_in = 4'h4;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_out", btn_out, 4'h0);
    chk("midreset_chg", btn_changed, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    push_exp(4'h4, 4'h4);
    drain(4'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
